uart_tx_fifo: RTL and testbench

Byte-wide transmit buffer that sits directly upstream of the UART transmitter. Host logic pushes bytes at any rate up to one per clock. The block stores them in a circular FIFO and feeds them one at a time to the transmitter's byte/enable inputs, pacing itself on the transmitter's busy flag. It also reports fill level and a sticky overflow error.

---
 rtl/uart_tx_fifo.sv | 117 +++++++++++
 tb/tb_uart_tx_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding a UART transmitter with busy-flag handshake
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr_ovf,
  input  logic          tx_bussy,
  output logic          tx_enable,
  output logic [7:0]    tx_byte,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          sent
);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          tx_en_q, tx_en_d;
  logic          sent_q, sent_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          push, pop;

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign tx_enable = tx_en_q;
  assign tx_byte   = tx_byte_q;
  assign sent      = sent_q;

  // Full is judged on the pre-edge count, so a pop in the same cycle never rescues a push.
  assign push = wr_en & ~full;

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    tx_en_d   = 1'b0;
    sent_d    = 1'b0;
    tx_byte_d = tx_byte_q;
    rd_ptr_d  = rd_ptr_q;
    case (state_q)
      IDLE: begin
        if (!empty && !tx_bussy) begin
          pop       = 1'b1;
          tx_byte_d = mem_q[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + 1'b1;
          tx_en_d   = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        // Enable is held until busy is seen, since the transmitter samples it only on a baud tick.
        if (tx_bussy) state_d = WAIT_DONE;
        else          tx_en_d = 1'b1;
      end
      WAIT_DONE: begin
        if (!tx_bussy) begin
          sent_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (wr_en && full) ovf_d = 1'b1;
    else if (clr_ovf)  ovf_d = 1'b0;
    else               ovf_d = ovf_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_en_q   <= 1'b0;
      sent_q    <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      tx_en_q   <= tx_en_d;
      sent_q    <= sent_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          clr_ovf = 1'b0;
  logic          tx_bussy = 1'b0;
  logic          tx_enable;
  logic [7:0]    tx_byte;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          sent;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q [$];

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
    .tx_bussy(tx_bussy), .tx_enable(tx_enable), .tx_byte(tx_byte), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .sent(sent)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Transmitter model: accepts n frames, each byte must match the host push order.
  task automatic tx_serve(input int n);
    logic [7:0] exp_b;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (tx_enable !== 1'b1 && t < 200) begin step(); t++; end
      vectors++;
      if (tx_enable !== 1'b1) begin
        miscompares++;
        $display("FAIL tx_enable_timeout: got %0b expected 1 frame %0d", tx_enable, i);
        return;
      end
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_frame: got byte %0h expected none", tx_byte);
        return;
      end
      exp_b = exp_q.pop_front();
      chk("tx_byte", {24'd0, tx_byte}, {24'd0, exp_b});
      repeat ($urandom_range(0, 2)) step();
      chk("enable_held", {31'd0, tx_enable}, 32'd1);
      tx_bussy = 1'b1;
      step();
      chk("enable_drop", {31'd0, tx_enable}, 32'd0);
      repeat ($urandom_range(1, 6)) step();
      chk("no_early_sent", {31'd0, sent}, 32'd0);
      tx_bussy = 1'b0;
      step();
      chk("sent_pulse", {31'd0, sent}, 32'd1);
      chk("tx_byte_stable", {24'd0, tx_byte}, {24'd0, exp_b});
    end
  endtask

  task automatic push_seq(input logic [7:0] b);
    wr_en = 1'b1; wr_data = b;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    chk("rst_enable", {31'd0, tx_enable}, 32'd0);
    rst = 1'b0;
    step();
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_txbyte", {24'd0, tx_byte}, 32'd0);
    chk("rst_sent", {31'd0, sent}, 32'd0);
  endtask

  task automatic test_single();
    int nsent = 0;
    tx_bussy = 1'b0;
    push_seq(8'hA5);
    chk("single_count1", {27'd0, count}, 32'd1);
    chk("single_noen", {31'd0, tx_enable}, 32'd0);
    step();
    chk("single_en", {31'd0, tx_enable}, 32'd1);
    chk("single_byte", {24'd0, tx_byte}, 32'hA5);
    chk("single_count0", {27'd0, count}, 32'd0);
    tx_bussy = 1'b1;
    step();
    chk("single_endrop", {31'd0, tx_enable}, 32'd0);
    repeat (19) begin step(); nsent += int'(sent); end
    tx_bussy = 1'b0;
    step();
    nsent += int'(sent);
    step();
    nsent += int'(sent);
    chk("single_sent_once", nsent, 32'd1);
    chk("single_empty", {31'd0, empty}, 32'd1);
  endtask

  task automatic test_burst();
    tx_bussy = 1'b1;
    step();
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'(i));
      push_seq(8'(i));
    end
    repeat (3) step();
    chk("burst_count", {27'd0, count}, 32'd5);
    chk("burst_nopop", {31'd0, tx_enable}, 32'd0);
    tx_bussy = 1'b0;
    tx_serve(5);
    chk("burst_empty", {31'd0, empty}, 32'd1);
  endtask

  task automatic test_fill();
    tx_bussy = 1'b1;
    step();
    for (int i = 0; i < DEPTH + 1; i++) begin
      logic [7:0] b = 8'($urandom);
      if (i < DEPTH) exp_q.push_back(b);
      push_seq(b);
    end
    chk("fill_count", {27'd0, count}, DEPTH);
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_ovf", {31'd0, overflow}, 32'd1);
    wr_en = 1'b1; clr_ovf = 1'b1; wr_data = 8'($urandom);
    step();
    wr_en = 1'b0;
    chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
    step();
    clr_ovf = 1'b0;
    chk("ovf_clear", {31'd0, overflow}, 32'd0);
    tx_bussy = 1'b0; wr_en = 1'b1; wr_data = 8'($urandom);
    step();
    wr_en = 1'b0;
    chk("full_pushpop_count", {27'd0, count}, DEPTH - 1);
    chk("full_pushpop_ovf", {31'd0, overflow}, 32'd1);
    chk("full_pushpop_en", {31'd0, tx_enable}, 32'd1);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    tx_serve(DEPTH);
    repeat (5) begin
      step();
      chk("fill_no_extra", {31'd0, tx_enable}, 32'd0);
    end
    chk("fill_empty", {31'd0, empty}, 32'd1);
  endtask

  task automatic test_simul();
    tx_bussy = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      logic [7:0] b = 8'($urandom);
      exp_q.push_back(b);
      push_seq(b);
    end
    chk("simul_pre", {27'd0, count}, 32'd3);
    tx_bussy = 1'b0; wr_en = 1'b1; wr_data = 8'($urandom);
    exp_q.push_back(wr_data);
    step();
    wr_en = 1'b0;
    chk("simul_count", {27'd0, count}, 32'd3);
    chk("simul_en", {31'd0, tx_enable}, 32'd1);
    tx_serve(4);
  endtask

  task automatic test_wrap();
    logic [7:0] base = 8'($urandom);
    tx_bussy = 1'b0;
    fork
      begin
        int pushed = 0;
        int guard = 0;
        while (pushed < 40 && guard < 5000) begin
          guard++;
          if (!full && $urandom_range(0, 3) != 0) begin
            wr_en = 1'b1; wr_data = base + 8'(pushed);
            exp_q.push_back(wr_data);
            pushed++;
          end else begin
            wr_en = 1'b0;
          end
          step();
        end
        wr_en = 1'b0;
      end
      tx_serve(40);
    join
    chk("wrap_ovf", {31'd0, overflow}, 32'd0);
    chk("wrap_empty", {31'd0, empty}, 32'd1);
  endtask

  task automatic test_reset_mid();
    int nsent = 0;
    tx_bussy = 1'b1;
    step();
    for (int i = 0; i < 5; i++) push_seq(8'($urandom));
    tx_bussy = 1'b0;
    step();
    chk("mid_start_en", {31'd0, tx_enable}, 32'd1);
    chk("mid_count4", {27'd0, count}, 32'd4);
    #3 rst = 1'b1;
    #1;
    chk("mid_en_async", {31'd0, tx_enable}, 32'd0);
    chk("mid_count0", {27'd0, count}, 32'd0);
    chk("mid_empty", {31'd0, empty}, 32'd1);
    step();
    rst = 1'b0;
    repeat (5) begin
      step();
      nsent += int'(sent);
      chk("mid_idle_noen", {31'd0, tx_enable}, 32'd0);
    end
    chk("mid_no_sent", nsent, 32'd0);
    exp_q.delete();
    exp_q.push_back(8'h3C);
    push_seq(8'h3C);
    tx_serve(1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_fill();
    test_simul();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
